// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate-generation stage.
// Decodes on the input side and buffers results in a two-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_SYSTEM = 1'b0,
  parameter bit          ENABLE_RV64_W = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_illegal,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] SEL_I    = 3'd0;
  localparam logic [2:0] SEL_S    = 3'd1;
  localparam logic [2:0] SEL_B    = 3'd2;
  localparam logic [2:0] SEL_U    = 3'd3;
  localparam logic [2:0] SEL_J    = 3'd4;
  localparam logic [2:0] SEL_NONE = 3'd7;

  localparam bit RV64_W_ON = ENABLE_RV64_W && (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            illegal;
    logic [31:0]     inst;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{imm: '0, sel: SEL_NONE, illegal: 1'b0, inst: '0};

  entry_t dec_c;
  logic [2:0] dec_sel_c;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_v_q, main_v_d;
  logic   skid_v_q, skid_v_d;
  logic   in_ready_q, in_ready_d;

  logic accept_c;
  logic drain_c;

  // Opcode classification
  always_comb begin
    dec_sel_c = SEL_NONE;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: dec_sel_c = SEL_I;
      7'b1110011, 7'b0001111: if (ENABLE_SYSTEM) dec_sel_c = SEL_I;
      7'b0011011:             if (RV64_W_ON)     dec_sel_c = SEL_I;
      7'b1100011:             dec_sel_c = SEL_B;
      7'b0100011:             dec_sel_c = SEL_S;
      7'b1101111:             dec_sel_c = SEL_J;
      7'b0010111, 7'b0110111: dec_sel_c = SEL_U;
      default:                dec_sel_c = SEL_NONE;
    endcase
  end

  // Immediate assembly; signed casts sign-extend each field from inst[31]
  always_comb begin
    dec_c         = ENTRY_EMPTY;
    dec_c.sel     = dec_sel_c;
    dec_c.illegal = (dec_sel_c == SEL_NONE);
    dec_c.inst    = in_inst;
    case (dec_sel_c)
      SEL_I:   dec_c.imm = XLEN'($signed(in_inst[31:20]));
      SEL_S:   dec_c.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      SEL_B:   dec_c.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                          in_inst[11:8], 1'b0}));
      SEL_U:   dec_c.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      SEL_J:   dec_c.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                          in_inst[30:21], 1'b0}));
      default: dec_c.imm = '0;
    endcase
  end

  assign accept_c = in_valid && in_ready_q;
  assign drain_c  = main_v_q && out_ready;

  // Skid buffer next state; skid is only ever occupied while main is occupied
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_d   = ENTRY_EMPTY;
      skid_d   = ENTRY_EMPTY;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept_c) begin
        main_d   = dec_c;
        main_v_d = 1'b1;
      end
    end else if (drain_c) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_d   = ENTRY_EMPTY;
        skid_v_d = 1'b0;
      end else if (accept_c) begin
        main_d   = dec_c;
      end else begin
        main_d   = ENTRY_EMPTY;
        main_v_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d   = dec_c;
      skid_v_d = 1'b1;
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= ENTRY_EMPTY;
      skid_q     <= ENTRY_EMPTY;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.illegal;
  assign out_inst    = main_q.inst;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one RV32 instance and one RV64 instance
// with all optional opcodes enabled, driven by the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a, inst_a;
  logic [2:0]  sel_a;
  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;
  logic [31:0] inst_b;
  logic [2:0]  sel_b;

  imm_gen_pipe #(.XLEN(32), .ENABLE_SYSTEM(1'b0), .ENABLE_RV64_W(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(imm_a),
    .out_sel(sel_a), .out_illegal(ill_a), .out_inst(inst_a));

  imm_gen_pipe #(.XLEN(64), .ENABLE_SYSTEM(1'b1), .ENABLE_RV64_W(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(imm_b),
    .out_sel(sel_b), .out_illegal(ill_b), .out_inst(inst_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] inst;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b, pa, pb;
  int   tests = 0;
  int   fails = 0;

  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [63:0] prev_imm_a, prev_imm_b;
  logic [31:0] prev_inst_a, prev_inst_b;
  logic [2:0]  prev_sel_a, prev_sel_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] sel, input logic ill);
    exp_t e;
    e.imm = imm; e.sel = sel; e.ill = ill; e.inst = 32'h0;
    return e;
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will do
  always @(negedge clk) begin
    if (reset) begin
      qa.delete(); qb.delete();
      hold_a = 1'b0; hold_b = 1'b0;
    end else begin
      if (hold_a) begin
        chk("hold_valid_a", 64'(out_valid_a), 64'd1);
        chk("hold_imm_a", 64'(imm_a), prev_imm_a);
        chk("hold_inst_a", 64'(inst_a), 64'(prev_inst_a));
        chk("hold_sel_a", 64'(sel_a), 64'(prev_sel_a));
      end
      if (hold_b) begin
        chk("hold_valid_b", 64'(out_valid_b), 64'd1);
        chk("hold_imm_b", imm_b, prev_imm_b);
        chk("hold_inst_b", 64'(inst_b), 64'(prev_inst_b));
        chk("hold_sel_b", 64'(sel_b), 64'(prev_sel_b));
      end
      if (out_valid_a && out_ready && !flush) begin
        if (qa.size() == 0) chk("unexpected_out_a", 64'(inst_a), 64'hDEAD);
        else begin
          pa = qa.pop_front();
          chk("imm_a", 64'(imm_a), pa.imm);
          chk("sel_a", 64'(sel_a), 64'(pa.sel));
          chk("ill_a", 64'(ill_a), 64'(pa.ill));
          chk("inst_a", 64'(inst_a), 64'(pa.inst));
        end
      end
      if (out_valid_b && out_ready && !flush) begin
        if (qb.size() == 0) chk("unexpected_out_b", 64'(inst_b), 64'hDEAD);
        else begin
          pb = qb.pop_front();
          chk("imm_b", imm_b, pb.imm);
          chk("sel_b", 64'(sel_b), 64'(pb.sel));
          chk("ill_b", 64'(ill_b), 64'(pb.ill));
          chk("inst_b", 64'(inst_b), 64'(pb.inst));
        end
      end
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (in_valid && in_ready_a) qa.push_back(cur_a);
        if (in_valid && in_ready_b) qb.push_back(cur_b);
      end
      hold_a = out_valid_a && !out_ready && !flush;
      hold_b = out_valid_b && !out_ready && !flush;
      prev_imm_a = 64'(imm_a); prev_inst_a = inst_a; prev_sel_a = sel_a;
      prev_imm_b = imm_b;      prev_inst_b = inst_b; prev_sel_b = sel_b;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input exp_t ea, input exp_t eb);
    in_inst = inst; in_valid = 1'b1;
    cur_a = ea; cur_a.inst = inst;
    cur_b = eb; cur_b.inst = inst;
  endtask

  // Holds in_valid until the edge that accepts the word; leaves in_valid high
  task automatic send(input logic [31:0] inst, input exp_t ea, input exp_t eb);
    int n;
    drive(inst, ea, eb);
    n = 0;
    while (!in_ready_a && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(in_ready_a), 64'd1);
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_inst  = 32'h0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || out_valid_a || out_valid_b) && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_done", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid_a"}, 64'(out_valid_a), 64'd0);
    chk({tag, "_ready_a"}, 64'(in_ready_a), 64'd1);
    chk({tag, "_imm_a"}, 64'(imm_a), 64'd0);
    chk({tag, "_sel_a"}, 64'(sel_a), 64'd7);
    chk({tag, "_ill_a"}, 64'(ill_a), 64'd0);
    chk({tag, "_inst_a"}, 64'(inst_a), 64'd0);
    chk({tag, "_valid_b"}, 64'(out_valid_b), 64'd0);
    chk({tag, "_ready_b"}, 64'(in_ready_b), 64'd1);
    chk({tag, "_imm_b"}, imm_b, 64'd0);
    chk({tag, "_sel_b"}, 64'(sel_b), 64'd7);
  endtask

  exp_t a_addi, b_addi, a_beq, b_beq, a_lui, b_lui, ill7;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0; out_ready = 1'b1;
    a_addi = mk(64'hFFFF_FFFF, 3'd0, 1'b0);
    b_addi = mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
    a_beq  = mk(64'hFFFF_FFFC, 3'd2, 1'b0);
    b_beq  = mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    a_lui  = mk(64'h1234_5000, 3'd3, 1'b0);
    b_lui  = mk(64'h1234_5000, 3'd3, 1'b0);
    ill7   = mk(64'h0, 3'd7, 1'b1);
    cur_a  = ill7; cur_b = ill7;

    #12;
    chk_reset_vals("rst");
    cyc();
    reset = 1'b0;

    // Single word: one-cycle latency
    cyc();
    send(32'hFFF0_0093, a_addi, b_addi);
    chk("latency_valid_a", 64'(out_valid_a), 64'd1);
    chk("latency_valid_b", 64'(out_valid_b), 64'd1);
    idle();
    drain();

    // Back-to-back stream across all formats and parameter-gated opcodes
    send(32'hFE00_0EE3, a_beq, b_beq);
    send(32'h1234_50B7, a_lui, b_lui);
    send(32'hFE20_AC23, mk(64'hFFFF_FFF8, 3'd1, 1'b0), mk(64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0));
    send(32'h0080_006F, mk(64'h8, 3'd4, 1'b0), mk(64'h8, 3'd4, 1'b0));
    send(32'h0040_2083, mk(64'h4, 3'd0, 1'b0), mk(64'h4, 3'd0, 1'b0));
    send(32'h0000_1097, mk(64'h1000, 3'd3, 1'b0), mk(64'h1000, 3'd3, 1'b0));
    send(32'h0000_80E7, mk(64'h0, 3'd0, 1'b0), mk(64'h0, 3'd0, 1'b0));
    send(32'h0000_007F, ill7, ill7);
    send(32'h0000_0073, ill7, mk(64'h0, 3'd0, 1'b0));
    send(32'h8000_00B7, mk(64'h8000_0000, 3'd3, 1'b0), mk(64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0));
    send(32'hFFF0_009B, ill7, mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0));
    send(32'h0FF0_000F, ill7, mk(64'hFF, 3'd0, 1'b0));
    idle();
    drain();

    // Backpressure: third word must wait until the first drain frees the skid
    out_ready = 1'b0;
    send(32'hFFF0_0093, a_addi, b_addi);
    send(32'hFE00_0EE3, a_beq, b_beq);
    drive(32'h1234_50B7, a_lui, b_lui);
    chk("bp_ready_low_a", 64'(in_ready_a), 64'd0);
    chk("bp_ready_low_b", 64'(in_ready_b), 64'd0);
    cyc();
    chk("bp_ready_still_low", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_rise_a", 64'(in_ready_a), 64'd1);
    chk("bp_ready_rise_b", 64'(in_ready_b), 64'd1);
    cyc();
    idle();
    drain();

    // Flush with both entries full and a same-cycle input
    out_ready = 1'b0;
    send(32'hFFF0_0093, a_addi, b_addi);
    send(32'hFE00_0EE3, a_beq, b_beq);
    drive(32'h1234_50B7, a_lui, b_lui);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    idle();
    chk("flush_valid_a", 64'(out_valid_a), 64'd0);
    chk("flush_ready_a", 64'(in_ready_a), 64'd1);
    chk("flush_valid_b", 64'(out_valid_b), 64'd0);
    chk("flush_ready_b", 64'(in_ready_b), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_empty_a", 64'(out_valid_a), 64'd0);
    end

    // Asynchronous reset mid-cycle with data buffered
    out_ready = 1'b0;
    send(32'h8000_00B7, mk(64'h8000_0000, 3'd3, 1'b0), mk(64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0));
    send(32'h0080_006F, mk(64'h8, 3'd4, 1'b0), mk(64'h8, 3'd4, 1'b0));
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("arst_empty_b", 64'(out_valid_b), 64'd0);
    end

    // Post-reset sanity word
    send(32'h1234_50B7, a_lui, b_lui);
    idle();
    drain();
    chk("scoreboard_empty", 64'(qa.size() + qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered immediate-generation stage for the RV32/RV64 decode path.
- Accepts one instruction word per cycle over a valid/ready handshake and classifies it by opcode (I/S/B/U/J).
- Assembles and sign-extends the immediate to XLEN and presents it downstream through a 2-entry skid buffer.
- Replaces the purely combinational imm-select decode; an unknown opcode raises an explicit illegal flag instead of driving high-Z.

Parameters:
XLEN, 32, datapath width of the immediate; legal values 32 or 64.
ENABLE_SYSTEM, 0, when 1, SYSTEM (1110011) and MISC-MEM (0001111) opcodes decode as I-type.
ENABLE_RV64_W, 0, when 1 and XLEN==64, OP-IMM-32 (0011011) decodes as I-type.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
in_inst  input  32  instruction word
out_valid  output  1  out_imm/out_sel/out_illegal/out_inst valid
out_ready  input  1  downstream accepts the head entry
out_imm  output  XLEN  sign-extended immediate
out_sel  output  3  format: 0=I 1=S 2=B 3=U 4=J 7=NONE
out_illegal  output  1  opcode not recognised
out_inst  output  32  instruction word passed through

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_sel=3'b111, out_illegal=0, out_inst=0. Both buffer entries are invalid.
- Opcode decode (in_inst[6:0]):
  - I-type: 0010011, 0000011, 1100111, plus the parameter-gated opcodes above.
  - B-type: 1100011.
  - S-type: 0100011.
  - J-type: 1101111.
  - U-type: 0010111, 0110111.
  - Anything else: sel=7, illegal=1, imm=0.
- Immediate assembly. The MSB of each field is inst[31]; it sign-extends to XLEN.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- Handshake:
  - A transfer occurs on a clock edge where valid&&ready.
  - in_ready is a registered signal: it is 1 iff the skid entry is empty. It must not combinationally depend on out_ready.
  - out_valid and all out_* signals are registered. They hold stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input accept to out_valid when the buffer is empty. Throughput is 1 instruction per cycle with out_ready held high.
- Buffer (main = head, skid = second):
  - Accept with main empty, or main draining this cycle with skid empty: the entry goes to main.
  - Accept while main is held (out_valid && !out_ready): the entry goes to skid, and in_ready drops next cycle.
  - Main drains while skid is full: skid moves to main, skid is cleared, and in_ready rises next cycle.
  - Strict FIFO order. No entry is ever dropped or duplicated.
- Simultaneous accept and drain with one entry held: main is replaced by the new entry; out_valid stays 1.
- Flush:
  - Clears both entries at the edge: out_valid=0, in_ready=1.
  - Flush has priority over any same-cycle input accept; that input is discarded.
  - out_ready is ignored during flush.
- Reset mid-transfer: all state returns to reset values immediately, without waiting for clk.
- Decode is performed on the input side, so the buffers store decoded results. No combinational path runs from in_inst to out_*.

Test Plan:
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> one cycle later out_valid=1, out_sel=0, out_imm=0xFFFFFFFF, out_illegal=0.
- Push 0xFE000EE3 (beq -4) -> out_sel=2, out_imm=0xFFFFFFFC. Push 0x123450B7 (lui) -> out_sel=3, out_imm=0x12345000.
- Backpressure: hold out_ready=0 and push three instructions on consecutive cycles.
  - The first two are accepted; in_ready=0 on the third cycle and the third is not accepted.
  - Raise out_ready: entries emerge in order and in_ready returns to 1 after the first drain.
- Push 0x0000007F -> out_illegal=1, out_sel=7, out_imm=0. Push 0x00000073 with ENABLE_SYSTEM=0 -> illegal; with ENABLE_SYSTEM=1 -> sel=0, imm=0.
- XLEN=64: push 0x800000B7 -> out_imm=0xFFFFFFFF80000000. With ENABLE_RV64_W=1, push 0xFFF0009B -> sel=0, imm=all ones.
- Fill both entries, then assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emerges.
- Assert reset asynchronously mid-stream -> outputs return to reset values before the next edge.
